// File: rtl/ahb_arbiter2.sv
// Two-master AHB-Lite arbiter. Each master gets a one-deep holding register.
// The holding register keeps a transfer that arrives while the other master
// owns the bus. The arbiter re-arbitrates only on HREADY=1. A master that owns
// the bus keeps it while it continues its burst with SEQ. The shared address
// phase is driven combinationally, so a granted transfer costs no extra cycle.
module ahb_arbiter2 #(
   parameter int ROUND_ROBIN = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic [31:0] M0_HWDATA,
   output logic [31:0] M0_HRDATA,
   output logic        M0_HREADY,
   output logic        M0_HRESP,
   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic [31:0] M1_HWDATA,
   output logic [31:0] M1_HRDATA,
   output logic        M1_HREADY,
   output logic        M1_HRESP,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        HMASTER
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_M0   = 2'd1;
   localparam logic [1:0] OWN_M1   = 2'd2;

   logic        pend0, pend1;
   logic [31:0] paddr0, paddr1;
   logic        pwrite0, pwrite1;
   logic [2:0]  psize0, psize1;
   logic [1:0]  data_owner;
   logic        last_grant;
   logic        hmaster_q;

   logic        pend_eff0, pend_eff1;
   logic        req0, req1;
   logic        owner_seq;
   logic        grant;
   logic        sel_pend;
   logic        capture0, capture1;

   // While reset is asserted, a held transfer is masked so that it never reaches the bus.
   assign pend_eff0 = pend0 & HRESETn;
   assign pend_eff1 = pend1 & HRESETn;
   assign req0      = pend_eff0 | M0_HTRANS[1];
   assign req1      = pend_eff1 | M1_HTRANS[1];
   assign owner_seq = hmaster_q ? (M1_HTRANS == TR_SEQ) : (M0_HTRANS == TR_SEQ);

   // Grant selection: hold while stalled or during the owner's burst, otherwise arbitrate.
   always_comb begin
      grant = hmaster_q;
      if (HREADY && !owner_seq) begin
         if (req0 && req1) begin
            grant = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
         end else if (req0) begin
            grant = 1'b0;
         end else if (req1) begin
            grant = 1'b1;
         end
      end
   end

   // Shared address phase: use the granted master's held copy if it has one, else its live signals.
   always_comb begin
      sel_pend = grant ? pend_eff1 : pend_eff0;
      HADDR    = grant ? M1_HADDR  : M0_HADDR;
      HTRANS   = grant ? M1_HTRANS : M0_HTRANS;
      HWRITE   = grant ? M1_HWRITE : M0_HWRITE;
      HSIZE    = grant ? M1_HSIZE  : M0_HSIZE;
      if (sel_pend) begin
         HADDR  = grant ? paddr1  : paddr0;
         HWRITE = grant ? pwrite1 : pwrite0;
         HSIZE  = grant ? psize1  : psize0;
         HTRANS = TR_NONSEQ;
      end
      if (!HRESETn) begin
         HTRANS = TR_IDLE;
      end
      HMASTER = grant;
   end

   // Data-phase routing and per-master ready and response signals.
   always_comb begin
      HWDATA = 32'h0;
      case (data_owner)
         OWN_M0:  HWDATA = M0_HWDATA;
         OWN_M1:  HWDATA = M1_HWDATA;
         default: HWDATA = 32'h0;
      endcase
      M0_HREADY = pend_eff0 ? 1'b0 : ((data_owner == OWN_M0) ? HREADY : 1'b1);
      M1_HREADY = pend_eff1 ? 1'b0 : ((data_owner == OWN_M1) ? HREADY : 1'b1);
      M0_HRESP  = (data_owner == OWN_M0) ? HRESP : 1'b0;
      M1_HRESP  = (data_owner == OWN_M1) ? HRESP : 1'b0;
      M0_HRDATA = HRDATA;
      M1_HRDATA = HRDATA;
   end

   // A master can see its transfer accepted without the grant taking effect. Such a transfer is parked here.
   assign capture0 = M0_HREADY & M0_HTRANS[1] & ~(HREADY & ~grant);
   assign capture1 = M1_HREADY & M1_HTRANS[1] & ~(HREADY & grant);

   // Holding registers: capture a transfer that was not granted, and clear it once it is issued.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         pend0   <= 1'b0;
         pend1   <= 1'b0;
         paddr0  <= 32'h0;
         paddr1  <= 32'h0;
         pwrite0 <= 1'b0;
         pwrite1 <= 1'b0;
         psize0  <= 3'h0;
         psize1  <= 3'h0;
      end else begin
         if (capture0) begin
            pend0   <= 1'b1;
            paddr0  <= M0_HADDR;
            pwrite0 <= M0_HWRITE;
            psize0  <= M0_HSIZE;
         end else if (HREADY && !grant) begin
            pend0 <= 1'b0;
         end
         if (capture1) begin
            pend1   <= 1'b1;
            paddr1  <= M1_HADDR;
            pwrite1 <= M1_HWRITE;
            psize1  <= M1_HSIZE;
         end else if (HREADY && grant) begin
            pend1 <= 1'b0;
         end
      end
   end

   // Arbitration state moves forward only when the bus accepts the address phase.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         data_owner <= OWN_NONE;
         last_grant <= 1'b1;
         hmaster_q  <= 1'b0;
      end else if (HREADY) begin
         hmaster_q <= grant;
         if (HTRANS[1]) begin
            data_owner <= grant ? OWN_M1 : OWN_M0;
            last_grant <= grant;
         end else begin
            data_owner <= OWN_NONE;
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter2.sv
// Bench for ahb_arbiter2. A per-cycle vector table drives the round-robin instance.
// A short hand-written sequence then checks the fixed-priority instance.
module tb_ahb_arbiter2;

   logic        clk;
   logic        rst_n;
   logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, hrdata;
   logic [1:0]  m0_htrans, m1_htrans;
   logic        m0_hwrite, m1_hwrite, hready, hresp;
   logic [2:0]  m0_hsize, m1_hsize;

   logic [31:0] rr_m0_hrdata, rr_m1_hrdata, rr_haddr, rr_hwdata;
   logic        rr_m0_hready, rr_m1_hready, rr_m0_hresp, rr_m1_hresp;
   logic [1:0]  rr_htrans;
   logic        rr_hwrite, rr_hmaster;
   logic [2:0]  rr_hsize;

   logic [31:0] fp_m0_hrdata, fp_m1_hrdata, fp_haddr, fp_hwdata;
   logic        fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp;
   logic [1:0]  fp_htrans;
   logic        fp_hwrite, fp_hmaster;
   logic [2:0]  fp_hsize;

   int n_chk = 0;
   int n_err = 0;
   logic watch_600 = 1'b0;

   ahb_arbiter2 #(.ROUND_ROBIN(1)) u_rr (
      .HCLK(clk), .HRESETn(rst_n),
      .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
      .M0_HWDATA(m0_hwdata), .M0_HRDATA(rr_m0_hrdata), .M0_HREADY(rr_m0_hready), .M0_HRESP(rr_m0_hresp),
      .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
      .M1_HWDATA(m1_hwdata), .M1_HRDATA(rr_m1_hrdata), .M1_HREADY(rr_m1_hready), .M1_HRESP(rr_m1_hresp),
      .HADDR(rr_haddr), .HTRANS(rr_htrans), .HWRITE(rr_hwrite), .HSIZE(rr_hsize), .HWDATA(rr_hwdata),
      .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HMASTER(rr_hmaster)
   );

   ahb_arbiter2 #(.ROUND_ROBIN(0)) u_fp (
      .HCLK(clk), .HRESETn(rst_n),
      .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
      .M0_HWDATA(m0_hwdata), .M0_HRDATA(fp_m0_hrdata), .M0_HREADY(fp_m0_hready), .M0_HRESP(fp_m0_hresp),
      .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
      .M1_HWDATA(m1_hwdata), .M1_HRDATA(fp_m1_hrdata), .M1_HREADY(fp_m1_hready), .M1_HRESP(fp_m1_hresp),
      .HADDR(fp_haddr), .HTRANS(fp_htrans), .HWRITE(fp_hwrite), .HSIZE(fp_hsize), .HWDATA(fp_hwdata),
      .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .HMASTER(fp_hmaster)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        resp;
      logic [1:0]  t0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [1:0]  t1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        chk;
      logic [1:0]  e_tr;
      logic [31:0] e_ad;
      logic        e_hm;
      logic [31:0] e_wd;
      logic        e_r0;
      logic        e_r1;
      logic        e_p0;
      logic        e_p1;
   } vec_t;

   vec_t vecs[33];

   function automatic vec_t mk(input logic rst, input logic rdy, input logic resp,
                               input logic [1:0] t0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [1:0] t1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic chk, input logic [1:0] e_tr, input logic [31:0] e_ad,
                               input logic e_hm, input logic [31:0] e_wd,
                               input logic e_r0, input logic e_r1, input logic e_p0, input logic e_p1);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.resp = resp;
      v.t0 = t0; v.a0 = a0; v.d0 = d0;
      v.t1 = t1; v.a1 = a1; v.d1 = d1;
      v.chk = chk; v.e_tr = e_tr; v.e_ad = e_ad; v.e_hm = e_hm; v.e_wd = e_wd;
      v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_p0 = e_p0; v.e_p1 = e_p1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // The held address 0x600 must never appear on the bus around the mid-transfer reset.
   always @(negedge clk) begin
      if (watch_600) begin
         n_chk++;
         if (rr_haddr == 32'h600) begin
            n_err++;
            $display("FAIL held_addr_leak: got 0x%08h expected not 0x00000600", rr_haddr);
         end
      end
   end

   initial begin
      rst_n = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      m0_haddr = 32'h0; m0_htrans = 2'b00; m0_hwrite = 1'b1; m0_hsize = 3'd2; m0_hwdata = 32'h0;
      m1_haddr = 32'h0; m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hsize = 3'd1; m1_hwdata = 32'h0;

      // single master read, slave wait, error response
      vecs[0]  = mk(0,1,0, 0,32'h0,0,             0,32'h0,0,       0, 0,32'h0,0,0,            0,0,0,0);
      vecs[1]  = mk(1,1,0, 0,32'h0,0,             0,32'h0,0,       1, 0,32'h0,0,0,            1,1,0,0);
      vecs[2]  = mk(1,1,0, 2,32'h10,0,            0,32'h0,0,       1, 2,32'h10,0,0,           1,1,0,0);
      vecs[3]  = mk(1,0,1, 0,32'h10,32'h55,       0,32'h0,0,       1, 0,32'h10,0,32'h55,      0,1,1,0);
      vecs[4]  = mk(1,1,0, 0,32'h10,32'h55,       0,32'h0,0,       1, 0,32'h10,0,32'h55,      1,1,0,0);
      // simultaneous requests straight after reset
      vecs[5]  = mk(0,1,0, 0,32'h0,0,             0,32'h0,0,       0, 0,32'h0,0,0,            0,0,0,0);
      vecs[6]  = mk(1,1,0, 2,32'h5000_0000,0,     2,32'h20,0,      1, 2,32'h5000_0000,0,0,    1,1,0,0);
      vecs[7]  = mk(1,1,0, 0,32'h5000_0000,32'h1234, 0,32'h20,0,   1, 2,32'h20,1,32'h1234,    1,0,0,0);
      vecs[8]  = mk(1,1,1, 0,32'h5000_0000,0,     0,32'h20,32'hBEEF, 1, 0,32'h20,1,32'hBEEF,  1,1,0,1);
      // continuous NONSEQ from both masters: alternation
      vecs[9]  = mk(0,1,0, 0,32'h0,0,             0,32'h0,0,       0, 0,32'h0,0,0,            0,0,0,0);
      vecs[10] = mk(1,1,0, 2,32'h100,0,           2,32'h200,0,     1, 2,32'h100,0,0,          1,1,0,0);
      vecs[11] = mk(1,1,0, 2,32'h104,32'hA100,    2,32'h204,32'hB200, 1, 2,32'h200,1,32'hA100, 1,0,0,0);
      vecs[12] = mk(1,1,0, 2,32'h108,32'hA104,    2,32'h204,32'hB200, 1, 2,32'h104,0,32'hB200, 0,1,0,0);
      vecs[13] = mk(1,1,0, 2,32'h108,32'hA104,    2,32'h208,32'hB204, 1, 2,32'h204,1,32'hA104, 1,0,0,0);
      vecs[14] = mk(1,1,0, 2,32'h10C,32'hA108,    2,32'h208,32'hB204, 1, 2,32'h108,0,32'hB204, 0,1,0,0);
      // three wait states in an M1 data phase while M0 requests
      vecs[15] = mk(0,1,0, 0,32'h0,0,             0,32'h0,0,       0, 0,32'h0,0,0,            0,0,0,0);
      vecs[16] = mk(1,1,0, 0,32'h0,0,             2,32'h300,0,     1, 2,32'h300,1,0,          1,1,0,0);
      vecs[17] = mk(1,0,0, 2,32'h400,0,           0,32'h300,32'hC300, 1, 0,32'h300,1,32'hC300, 1,0,0,0);
      vecs[18] = mk(1,0,0, 0,32'h400,32'hD400,    0,32'h300,32'hC300, 1, 0,32'h300,1,32'hC300, 0,0,0,0);
      vecs[19] = mk(1,0,0, 0,32'h400,32'hD400,    0,32'h300,32'hC300, 1, 0,32'h300,1,32'hC300, 0,0,0,0);
      vecs[20] = mk(1,1,0, 0,32'h400,32'hD400,    0,32'h300,32'hC300, 1, 2,32'h400,0,32'hC300, 0,1,0,0);
      vecs[21] = mk(1,1,0, 0,32'h400,32'hD400,    0,32'h300,0,     1, 0,32'h400,0,32'hD400,   1,1,0,0);
      // reset while M1 holds a pending transfer
      vecs[22] = mk(0,1,0, 0,32'h0,0,             0,32'h0,0,       0, 0,32'h0,0,0,            0,0,0,0);
      vecs[23] = mk(1,1,0, 2,32'h500,0,           2,32'h600,0,     1, 2,32'h500,0,0,          1,1,0,0);
      vecs[24] = mk(0,1,0, 0,32'h500,32'hE500,    2,32'h604,0,     0, 0,32'h0,0,0,            0,0,0,0);
      vecs[25] = mk(1,1,0, 0,32'h500,0,           0,32'h604,0,     1, 0,32'h500,0,0,          1,1,0,0);
      vecs[26] = mk(1,1,0, 0,32'h500,0,           2,32'h700,0,     1, 2,32'h700,1,0,          1,1,0,0);
      // M1 burst NONSEQ + 3 SEQ with M0 requesting, then BUSY pass-through
      vecs[27] = mk(1,1,0, 2,32'h800,0,           3,32'h704,32'hF700, 1, 3,32'h704,1,32'hF700, 1,1,0,0);
      vecs[28] = mk(1,1,0, 0,32'h800,32'hA800,    3,32'h708,32'hF704, 1, 3,32'h708,1,32'hF704, 0,1,0,0);
      vecs[29] = mk(1,1,0, 0,32'h800,32'hA800,    3,32'h70C,32'hF708, 1, 3,32'h70C,1,32'hF708, 0,1,0,0);
      vecs[30] = mk(1,1,0, 0,32'h800,32'hA800,    0,32'h70C,32'hF70C, 1, 2,32'h800,0,32'hF70C, 0,1,0,0);
      vecs[31] = mk(1,1,0, 0,32'h800,32'hA800,    0,32'h70C,0,     1, 0,32'h800,0,32'hA800,   1,1,0,0);
      vecs[32] = mk(1,1,0, 1,32'h804,0,           0,32'h70C,0,     1, 1,32'h804,0,0,          1,1,0,0);

      @(posedge clk); #1;
      for (int i = 0; i < 33; i++) begin
         rst_n = vecs[i].rst; hready = vecs[i].rdy; hresp = vecs[i].resp;
         hrdata = 32'hD000_0000 + i;
         m0_htrans = vecs[i].t0; m0_haddr = vecs[i].a0; m0_hwdata = vecs[i].d0;
         m1_htrans = vecs[i].t1; m1_haddr = vecs[i].a1; m1_hwdata = vecs[i].d1;
         watch_600 = (i >= 24 && i <= 26);
         @(negedge clk);
         if (vecs[i].chk) begin
            check($sformatf("v%0d htrans", i),  {30'h0, rr_htrans},    {30'h0, vecs[i].e_tr});
            check($sformatf("v%0d haddr", i),   rr_haddr,              vecs[i].e_ad);
            check($sformatf("v%0d hmaster", i), {31'h0, rr_hmaster},   {31'h0, vecs[i].e_hm});
            check($sformatf("v%0d hwdata", i),  rr_hwdata,             vecs[i].e_wd);
            check($sformatf("v%0d m0_hready", i), {31'h0, rr_m0_hready}, {31'h0, vecs[i].e_r0});
            check($sformatf("v%0d m1_hready", i), {31'h0, rr_m1_hready}, {31'h0, vecs[i].e_r1});
            check($sformatf("v%0d m0_hresp", i),  {31'h0, rr_m0_hresp},  {31'h0, vecs[i].e_p0});
            check($sformatf("v%0d m1_hresp", i),  {31'h0, rr_m1_hresp},  {31'h0, vecs[i].e_p1});
            check($sformatf("v%0d hwrite", i),  {31'h0, rr_hwrite},    {31'h0, ~vecs[i].e_hm});
            check($sformatf("v%0d hsize", i),   {29'h0, rr_hsize},     vecs[i].e_hm ? 32'd1 : 32'd2);
            check($sformatf("v%0d m0_hrdata", i), rr_m0_hrdata,        32'hD000_0000 + i);
            check($sformatf("v%0d m1_hrdata", i), rr_m1_hrdata,        32'hD000_0000 + i);
         end
         @(posedge clk); #1;
      end
      watch_600 = 1'b0;

      // fixed priority: M0 keeps the bus under continuous requests from both masters
      rst_n = 1'b0; hready = 1'b1; hresp = 1'b0;
      m0_htrans = 2'b00; m1_htrans = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1; hrdata = 32'h1357;
      m0_htrans = 2'b10; m0_haddr = 32'h900; m0_hwdata = 32'h77;
      m1_htrans = 2'b10; m1_haddr = 32'hA00; m1_hwdata = 32'h88;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("fp%0d hmaster", k),   {31'h0, fp_hmaster},   32'd0);
         check($sformatf("fp%0d haddr", k),     fp_haddr,              32'h900);
         check($sformatf("fp%0d htrans", k),    {30'h0, fp_htrans},    32'd2);
         check($sformatf("fp%0d hwrite", k),    {31'h0, fp_hwrite},    32'd1);
         check($sformatf("fp%0d hsize", k),     {29'h0, fp_hsize},     32'd2);
         check($sformatf("fp%0d hwdata", k),    fp_hwdata,             (k == 0) ? 32'h0 : 32'h77);
         check($sformatf("fp%0d m0_hready", k), {31'h0, fp_m0_hready}, 32'd1);
         check($sformatf("fp%0d m1_hready", k), {31'h0, fp_m1_hready}, (k == 0) ? 32'd1 : 32'd0);
         check($sformatf("fp%0d hresp", k),     {30'h0, fp_m0_hresp, fp_m1_hresp}, 32'd0);
         check($sformatf("fp%0d hrdata", k),    fp_m0_hrdata ^ fp_m1_hrdata ^ 32'h1357, 32'h1357);
         check($sformatf("rr%0d hmaster", k),   {31'h0, rr_hmaster},   k % 2);
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
